// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/shift/rotate/load/clear modes plus an MSB-first burst serialiser.
// Optional even-parity output is built when USR_PARITY_EN is defined.
module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pi,
  input  logic             sil,
  input  logic             sir,
  input  logic             start,
  output logic [WIDTH-1:0] po,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
`ifdef USR_PARITY_EN
  output logic             done,
  output logic             parity
`else
  output logic             done
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  logic [CW-1:0] cnt;

  function automatic logic [WIDTH-1:0] op_next(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d,
    input logic             sl,
    input logic             sr
  );
    case (m)
      M_HOLD:  op_next = q;
      M_SHL:   op_next = {q[WIDTH-2:0], sl};
      M_SHR:   op_next = {sr, q[WIDTH-1:1]};
      M_ROL:   op_next = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ROR:   op_next = {q[0], q[WIDTH-1:1]};
      M_LOAD:  op_next = d;
      M_ASR:   op_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default: op_next = '0;
    endcase
  endfunction

  // Burst: load edge + WIDTH-1 shift edges keep busy high for exactly WIDTH cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      po   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (cnt != '0) begin
          po  <= {po[WIDTH-2:0], sil};
          cnt <= cnt - CW'(1);
        end else begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        po   <= pi;
        busy <= 1'b1;
        cnt  <= CNT_LAST;
      end else if (en) begin
        po <= op_next(mode, po, pi, sil, sir);
      end
    end
  end

  assign so_msb = po[WIDTH-1];
  assign so_lsb = po[0];

`ifdef USR_PARITY_EN
  assign parity = ^po;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomised self-checking bench for univ_shift_reg (WIDTH=8) against an arithmetic reference model.
// Build with +define+USR_PARITY_EN to also exercise the parity output.
module tb_univ_shift_reg;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic [W-1:0] pi = '0;
  logic         sil = 1'b0;
  logic         sir = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] po;
  logic         so_msb, so_lsb, busy, done;
`ifdef USR_PARITY_EN
  logic         parity;
`endif

  int tests = 0;
  int fails = 0;

  // reference model state
  int m_po = 0;
  int m_busy = 0;
  int m_done = 0;
  int m_shifts = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .pi(pi),
    .sil(sil), .sir(sir), .start(start),
    .po(po), .so_msb(so_msb), .so_lsb(so_lsb), .busy(busy),
`ifdef USR_PARITY_EN
    .done(done), .parity(parity)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_po = 0; m_busy = 0; m_done = 0; m_shifts = 0;
  endtask

  // Next state from the behavioural rules, using the inputs present at the edge.
  task automatic model_update();
    int nd;
    if (rst !== 1'b1) begin
      model_reset();
      return;
    end
    nd = 0;
    if (m_busy != 0) begin
      if (m_shifts < W - 1) begin
        m_po = (m_po * 2 + int'(sil)) % 256;
        m_shifts++;
      end else begin
        m_busy = 0;
        nd = 1;
      end
    end else if (start) begin
      m_po = int'(pi);
      m_busy = 1;
      m_shifts = 0;
    end else if (en) begin
      case (mode)
        3'd1: m_po = (m_po * 2 + int'(sil)) % 256;
        3'd2: m_po = m_po / 2 + int'(sir) * 128;
        3'd3: m_po = (m_po * 2) % 256 + m_po / 128;
        3'd4: m_po = m_po / 2 + (m_po % 2) * 128;
        3'd5: m_po = int'(pi);
        3'd6: m_po = m_po / 2 + (m_po / 128) * 128;
        3'd7: m_po = 0;
        default: ;
      endcase
    end
    m_done = nd;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic async_reset_pulse();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_po", po, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #1;
    rst = 1'b1;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    e = W'(m_po);
    chk("po", po, e);
    chk("busy_done", {busy, done}, {m_busy[0], m_done[0]});
    chk("so", {so_msb, so_lsb}, {e[W-1], e[0]});
`ifdef USR_PARITY_EN
    chk("parity", parity, $countones(e) % 2);
`endif
  end

  initial begin
    logic [W-1:0] seq;
    #1 rst = 1'b0;
    model_reset();
    step(); step();
    chk("reset_state", {po, busy, done}, 0);
    rst = 1'b1;

    // directed mode checks
    en = 1'b1; mode = 3'b101; pi = 8'h96; step(); chk("lit_load", po, 8'h96);
    mode = 3'b011; step(); chk("lit_rol", po, 8'h2D);
    mode = 3'b100; step(); chk("lit_ror", po, 8'h96);
    mode = 3'b110; sir = 1'b1; step(); chk("lit_asr", po, 8'hCB);
    mode = 3'b010; sir = 1'b0; step(); chk("lit_shr", po, 8'h65);
    mode = 3'b101; pi = 8'h96; step();
    mode = 3'b001; sil = 1'b1; step(); chk("lit_shl", po, 8'h2D);
    en = 1'b0; mode = 3'b111; step(); chk("lit_en0", po, 8'h2D);
    en = 1'b1; step(); chk("lit_clr", po, 8'h00);

    // async reset with po=A5, checked before the next edge
    mode = 3'b101; pi = 8'hA5; step(); chk("lit_a5", po, 8'hA5);
    async_reset_pulse();

    // single burst B4
    en = 1'b0; start = 1'b1; pi = 8'hB4; sil = 1'b0; step();
    start = 1'b0;
    seq = '0;
    for (int i = 0; i < W; i++) begin
      seq[W-1-i] = so_msb;
      chk("burst_busy", busy, 1);
      step();
    end
    chk("burst_seq", seq, 8'hB4);
    chk("burst_end", {po, busy, done}, {8'h00, 1'b0, 1'b1});

    // back-to-back: start in the done cycle, noise on inputs during burst
    start = 1'b1; pi = 8'hA5; step(); start = 1'b0;
    for (int i = 0; i < W; i++) step();
    chk("b2b_done", done, 1);
    start = 1'b1; pi = 8'h0F; step();
    seq = '0;
    for (int i = 0; i < W; i++) begin
      seq[W-1-i] = so_msb;
      chk("b2b_busy", busy, 1);
      start = 1'($urandom_range(0, 1)); en = 1'($urandom_range(0, 1));
      mode = 3'($urandom_range(0, 7)); pi = 8'($urandom_range(0, 255));
      step();
    end
    chk("b2b_seq", seq, 8'h0F);
    start = 1'b0; step();

    // reset at cycle 3 of a burst: no done pulse afterwards
    start = 1'b1; pi = 8'hC3; step(); start = 1'b0;
    step(); step();
    async_reset_pulse();
    for (int i = 0; i < W + 2; i++) begin
      chk("abort_nodone", {busy, done}, 2'b00);
      step();
    end

`ifdef USR_PARITY_EN
    en = 1'b1; mode = 3'b101; pi = 8'h07; step(); chk("lit_par1", parity, 1);
    pi = 8'h03; step(); chk("lit_par0", parity, 0);
`endif

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
      mode = 3'($urandom_range(0, 7));
      pi = 8'($urandom_range(0, 255));
      sil = 1'($urandom_range(0, 1));
      sir = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 9) == 0);
      step();
      if ($urandom_range(0, 99) == 0) async_reset_pulse();
    end

    start = 1'b0; en = 1'b0;
    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
